conv_tran_sched: RTL and testbench

Single-clock sequencer for the K×K transposed-convolution PE array and its row-psum FIFOs. It runs the full CO×CI channel loop. For each pass it loads K*K weights through one-hot set_wgt strobes, then streams IFM_SIZE² pixels with a valid/ready-style stall, then drains K-1 zero rows. It also drives the FIFO, psum-buffer and output-valid strobes, and pulses end_conv once after the last pass.

---
 rtl/conv_tran_sched_if.sv | 40 ++++
 rtl/conv_tran_sched.sv | 184 ++++++++++++++++++
 tb/tb_conv_tran_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_tran_sched_if.sv
// Control bundle between the transposed-convolution sequencer and the PE array,
// weight/IFM input buses and row-psum FIFOs.
interface conv_tran_sched_if #(
    parameter int KERNEL_SIZE = 5,
    parameter int CI          = 3,
    parameter int CO          = 8
);
    localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CI_W = $clog2(CI) + 1;
    localparam int CO_W = $clog2(CO) + 1;

    logic                   start_conv;
    logic                   wgt_valid;
    logic                   ifm_valid;
    logic                   wgt_read;
    logic                   ifm_read;
    logic [KK-1:0]          set_wgt;
    logic                   set_ifm;
    logic                   ifm_zero;
    logic                   set_reg;
    logic [KERNEL_SIZE-1:0] wr_en;
    logic [KERNEL_SIZE-1:0] rd_en;
    logic                   re_buffer;
    logic                   out_valid;
    logic                   end_conv;
    logic [CI_W-1:0]        ci_idx;
    logic [CO_W-1:0]        co_idx;

    modport master (
        input  start_conv, wgt_valid, ifm_valid,
        output wgt_read, ifm_read, set_wgt, set_ifm, ifm_zero, set_reg,
               wr_en, rd_en, re_buffer, out_valid, end_conv, ci_idx, co_idx
    );

    modport slave (
        output start_conv, wgt_valid, ifm_valid,
        input  wgt_read, ifm_read, set_wgt, set_ifm, ifm_zero, set_reg,
               wr_en, rd_en, re_buffer, out_valid, end_conv, ci_idx, co_idx
    );
endinterface

// File: rtl/conv_tran_sched.sv
// Channel-loop sequencer for the KxK transposed-convolution PE array: per pass it
// loads K*K weights, streams IFM_SIZE^2 pixels, then drains K-1 zero rows.
module conv_tran_sched #(
    parameter int KERNEL_SIZE = 5,
    parameter int IFM_SIZE    = 64,
    parameter int CI          = 3,
    parameter int CO          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_tran_sched_if.master     bus
);
    localparam int KK        = KERNEL_SIZE * KERNEL_SIZE;
    localparam int DRAIN_LEN = (KERNEL_SIZE - 1) * IFM_SIZE;
    localparam int WGT_W     = $clog2(KK) + 1;
    localparam int PIX_W     = $clog2(IFM_SIZE) + 1;
    localparam int DRN_W     = $clog2(DRAIN_LEN) + 1;
    localparam int CI_W      = $clog2(CI) + 1;
    localparam int CO_W      = $clog2(CO) + 1;

    localparam logic [WGT_W-1:0] WGT_LAST = WGT_W'(KK - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IFM_SIZE - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_LEN - 1);
    localparam logic [CI_W-1:0]  CI_LAST  = CI_W'(CI - 1);
    localparam logic [CO_W-1:0]  CO_LAST  = CO_W'(CO - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_WGT, STREAM, DRAIN, NEXT, DONE
    } state_t;

    state_t                 state;
    logic [WGT_W-1:0]       wgt_cnt;
    logic [PIX_W-1:0]       col;
    logic [PIX_W-1:0]       row;
    logic [DRN_W-1:0]       drain_cnt;
    logic [CI_W-1:0]        ci;
    logic [CO_W-1:0]        co;

    logic                   set_reg_q;
    logic [KERNEL_SIZE-1:0] wr_en_q;
    logic [KERNEL_SIZE-1:0] rd_en_q;
    logic                   re_buffer_q;
    logic                   out_valid_q;
    logic                   end_conv_q;

    logic wgt_acc;
    logic ifm_acc;
    logic pe_step;
    logic row_gt0;

    // Handshake strobes are combinational in state so a word is taken the same cycle it is offered.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        bus.wgt_read = 1'b0;
        bus.ifm_read = 1'b0;
        bus.set_wgt  = '0;
        bus.set_ifm  = 1'b0;
        bus.ifm_zero = 1'b0;
        wgt_acc      = 1'b0;
        ifm_acc      = 1'b0;
        pe_step      = 1'b0;
        row_gt0      = (row != '0);
        case (state)
            LOAD_WGT: begin
                bus.wgt_read = 1'b1;
                wgt_acc      = bus.wgt_valid;
                if (wgt_acc) bus.set_wgt = KK'(1) << wgt_cnt;
            end
            STREAM: begin
                bus.ifm_read = 1'b1;
                ifm_acc      = bus.ifm_valid;
                bus.set_ifm  = ifm_acc;
                pe_step      = ifm_acc;
            end
            DRAIN: begin
                bus.set_ifm  = 1'b1;
                bus.ifm_zero = 1'b1;
                pe_step      = 1'b1;
                row_gt0      = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wgt_cnt     <= '0;
            col         <= '0;
            row         <= '0;
            drain_cnt   <= '0;
            ci          <= '0;
            co          <= '0;
            set_reg_q   <= 1'b0;
            wr_en_q     <= '0;
            rd_en_q     <= '0;
            re_buffer_q <= 1'b0;
            out_valid_q <= 1'b0;
            end_conv_q  <= 1'b0;
        end else begin
            // Array strobes trail the accepted pixel by exactly one cycle.
            set_reg_q   <= pe_step;
            wr_en_q     <= {KERNEL_SIZE{pe_step}};
            rd_en_q     <= {KERNEL_SIZE{pe_step && row_gt0}};
            re_buffer_q <= pe_step && (ci != '0);
            out_valid_q <= pe_step && row_gt0 && (ci == CI_LAST);
            end_conv_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start_conv) begin
                        ci      <= '0;
                        co      <= '0;
                        wgt_cnt <= '0;
                        state   <= LOAD_WGT;
                    end
                end
                LOAD_WGT: begin
                    if (wgt_acc) begin
                        if (wgt_cnt == WGT_LAST) begin
                            wgt_cnt <= '0;
                            col     <= '0;
                            row     <= '0;
                            state   <= STREAM;
                        end else begin
                            wgt_cnt <= wgt_cnt + WGT_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (ifm_acc) begin
                        if (col == PIX_LAST) begin
                            col <= '0;
                            if (row == PIX_LAST) begin
                                row       <= '0;
                                drain_cnt <= '0;
                                state     <= DRAIN;
                            end else begin
                                row <= row + PIX_W'(1);
                            end
                        end else begin
                            col <= col + PIX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRN_LAST) begin
                        drain_cnt <= '0;
                        state     <= NEXT;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end
                NEXT: begin
                    if (ci != CI_LAST) begin
                        ci    <= ci + CI_W'(1);
                        state <= LOAD_WGT;
                    end else begin
                        ci <= '0;
                        if (co != CO_LAST) begin
                            co    <= co + CO_W'(1);
                            state <= LOAD_WGT;
                        end else begin
                            end_conv_q <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.set_reg   = set_reg_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.re_buffer = re_buffer_q;
    assign bus.out_valid = out_valid_q;
    assign bus.end_conv  = end_conv_q;
    assign bus.ci_idx    = ci;
    assign bus.co_idx    = co;
endmodule

// File: tb/tb_conv_tran_sched.sv
// Scoreboard bench for conv_tran_sched: the driver queues expected strobes with their
// cycle stamps, a negedge monitor pops and compares whenever the DUT emits one.
module tb_conv_tran_sched;
    localparam int K    = 3;
    localparam int KK   = K * K;
    localparam int IFM  = 4;
    localparam int CI   = 2;
    localparam int CO   = 2;
    localparam int DRN  = (K - 1) * IFM;
    localparam int CI_W = $clog2(CI) + 1;
    localparam int CO_W = $clog2(CO) + 1;

    typedef struct packed {
        int            cyc;
        logic [KK-1:0] hot;
    } wrec_t;

    typedef struct packed {
        int              cyc;
        logic            rd;
        logic            re;
        logic            ov;
        logic [CI_W-1:0] ci;
        logic [CO_W-1:0] co;
    } srec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    wrec_t wq[$];
    srec_t sq[$];
    int    eq[$];

    // 0 set_wgt, 1 ifm accept, 2 ifm_zero, 3 set_reg, 4 out_valid, 5 out_valid@ci1, 6 re_buffer, 7 end_conv
    int cnt[8];
    // small DUT: 0 set_reg, 1 out_valid, 2 re_buffer, 3 end_conv
    int scnt[4];
    int s_end_cyc = 0;

    conv_tran_sched_if #(.KERNEL_SIZE(K), .CI(CI), .CO(CO)) bus ();
    conv_tran_sched_if #(.KERNEL_SIZE(K), .CI(1),  .CO(1))  bus_s ();

    conv_tran_sched #(.KERNEL_SIZE(K), .IFM_SIZE(IFM), .CI(CI), .CO(CO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_tran_sched #(.KERNEL_SIZE(K), .IFM_SIZE(IFM), .CI(1), .CO(1)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.start_conv = bus.start_conv;
    assign bus_s.wgt_valid  = bus.wgt_valid;
    assign bus_s.ifm_valid  = bus.ifm_valid;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.wgt_read, bus.ifm_read, bus.set_wgt, bus.set_ifm, bus.ifm_zero,
                    bus.set_reg, bus.wr_en, bus.rd_en, bus.re_buffer, bus.out_valid,
                    bus.end_conv, bus.ci_idx, bus.co_idx});
    endfunction

    initial begin : monitor
        wrec_t w;
        srec_t s;
        forever begin
            @(negedge clk);
            check("read_exclusive", 64'(bus.wgt_read & bus.ifm_read), 64'd0);
            if (bus.ifm_read) check("zero_in_stream", 64'(bus.ifm_zero), 64'd0);
            if (bus.ifm_read && bus.ifm_valid) cnt[1] = cnt[1] + 1;
            if (bus.ifm_zero) cnt[2] = cnt[2] + 1;
            if (bus.set_wgt != '0) begin
                cnt[0] = cnt[0] + 1;
                if (wq.size() == 0) begin
                    check("set_wgt_unexpected", 64'(bus.set_wgt), 64'd0);
                end else begin
                    w = wq.pop_front();
                    check("set_wgt", 64'({cyc[15:0], bus.set_wgt}), 64'({w.cyc[15:0], w.hot}));
                end
            end
            if (bus.set_reg) begin
                cnt[3] = cnt[3] + 1;
                if (bus.out_valid) cnt[4] = cnt[4] + 1;
                if (bus.out_valid && bus.ci_idx == CI_W'(1)) cnt[5] = cnt[5] + 1;
                if (bus.re_buffer) cnt[6] = cnt[6] + 1;
                if (sq.size() == 0) begin
                    check("set_reg_unexpected", 64'(bus.set_reg), 64'd0);
                end else begin
                    s = sq.pop_front();
                    check("strobes",
                          64'({cyc[15:0], bus.rd_en, bus.wr_en, bus.re_buffer, bus.out_valid,
                               bus.ci_idx, bus.co_idx}),
                          64'({s.cyc[15:0], {K{s.rd}}, {K{1'b1}}, s.re, s.ov, s.ci, s.co}));
                end
            end
            if (bus.end_conv) begin
                cnt[7] = cnt[7] + 1;
                if (eq.size() == 0) check("end_conv_unexpected", 64'(bus.end_conv), 64'd0);
                else check("end_conv_cycle", 64'(cyc), 64'(eq.pop_front()));
            end
            if (bus_s.set_reg)   scnt[0] = scnt[0] + 1;
            if (bus_s.out_valid) scnt[1] = scnt[1] + 1;
            if (bus_s.re_buffer) scnt[2] = scnt[2] + 1;
            if (bus_s.end_conv) begin
                scnt[3]   = scnt[3] + 1;
                s_end_cyc = cyc;
            end
        end
    end

    // One full CO x CI run. stall_at inserts 5 idle pixel slots in pass 0; abort_pass/abort_px
    // raise rst at that stream slot instead of completing.
    task automatic run(input bit gaps, input int stall_at, input int abort_pass,
                       input int abort_px, input int end_off, output int t0);
        int    pass;
        int    k;
        int    n;
        int    last;
        bit    ph;
        wrec_t w;
        srec_t s;
        pass = 0;
        t0   = cyc;
        bus.start_conv = 1'b1;
        if (abort_pass < 0) eq.push_back(t0 + end_off);
        @(posedge clk); #1;
        bus.start_conv = 1'b0;
        for (int co = 0; co < CO; co++) begin
            for (int ci = 0; ci < CI; ci++) begin
                n = 0;
                while (!bus.wgt_read && n < 40) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("wgt_read_ready", 64'(bus.wgt_read), 64'd1);
                k  = 0;
                ph = 1'b0;
                while (k < KK) begin
                    if (gaps && ph) begin
                        bus.wgt_valid = 1'b0;
                    end else begin
                        bus.wgt_valid = 1'b1;
                        w.cyc = cyc;
                        w.hot = KK'(1) << k;
                        wq.push_back(w);
                        k++;
                    end
                    if (gaps) ph = !ph;
                    @(posedge clk); #1;
                end
                bus.wgt_valid = 1'b0;
                check("stream_entry", 64'({bus.ifm_read, bus.wgt_read}), 64'b10);
                last = cyc;
                for (int p = 0; p < IFM * IFM; p++) begin
                    if (pass == abort_pass && p == abort_px) begin
                        bus.ifm_valid = 1'b0;
                        rst = 1'b1;
                        @(posedge clk); #1;
                        check("outputs_after_midrun_rst", outs(), 64'd0);
                        check("queues_after_midrun_rst", 64'(wq.size() + sq.size()), 64'd0);
                        rst = 1'b0;
                        wq.delete();
                        sq.delete();
                        return;
                    end
                    if (pass == 0 && p == stall_at) begin
                        bus.ifm_valid = 1'b0;
                        repeat (5) begin
                            @(posedge clk); #1;
                        end
                    end
                    bus.ifm_valid = 1'b1;
                    s.cyc = cyc + 1;
                    s.rd  = (p >= IFM);
                    s.re  = (ci > 0);
                    s.ov  = (ci == CI - 1) && (p >= IFM);
                    s.ci  = CI_W'(ci);
                    s.co  = CO_W'(co);
                    sq.push_back(s);
                    last = cyc;
                    @(posedge clk); #1;
                end
                bus.ifm_valid = 1'b0;
                for (int j = 0; j < DRN; j++) begin
                    s.cyc = last + 2 + j;
                    s.rd  = 1'b1;
                    s.re  = (ci > 0);
                    s.ov  = (ci == CI - 1);
                    s.ci  = CI_W'(ci);
                    s.co  = CO_W'(co);
                    sq.push_back(s);
                end
                pass++;
            end
        end
        n = 0;
        while (eq.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("queues_drained", 64'(wq.size() + sq.size() + eq.size()), 64'd0);
        check("idle_after_run", 64'({bus.wgt_read, bus.ifm_read, bus.end_conv}), 64'd0);
    endtask

    task automatic check_totals(input int base[8]);
        int exp_tot[8];
        exp_tot = '{36, 64, 32, 96, 40, 40, 48, 1};
        for (int i = 0; i < 8; i++)
            check($sformatf("total[%0d]", i), 64'(cnt[i] - base[i]), 64'(exp_tot[i]));
    endtask

    initial begin : driver
        int base[8];
        int sbase[4];
        int t0;
        rst            = 1'b1;
        bus.start_conv = 1'b1;
        bus.wgt_valid  = 1'b0;
        bus.ifm_valid  = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_outputs", outs(), 64'd0);
        end
        rst            = 1'b0;
        bus.start_conv = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", outs(), 64'd0);

        // Full run, no gaps or stalls; the CI=1/CO=1 instance runs its single pass alongside.
        base  = cnt;
        sbase = scnt;
        run(1'b0, -1, -1, -1, 4 * (KK + IFM * IFM + DRN + 1) + 1, t0);
        check_totals(base);
        check("small_set_reg", 64'(scnt[0] - sbase[0]), 64'd24);
        check("small_out_valid", 64'(scnt[1] - sbase[1]), 64'd20);
        check("small_re_buffer", 64'(scnt[2] - sbase[2]), 64'd0);
        check("small_end_conv", 64'(scnt[3] - sbase[3]), 64'd1);
        check("small_end_cycle", 64'(s_end_cyc), 64'(t0 + KK + IFM * IFM + DRN + 1 + 1));

        // Weight gaps every other cycle (+8 per pass) and a 5-cycle pixel stall mid-row 1.
        base = cnt;
        run(1'b1, IFM + 2, -1, -1, 4 * (KK + IFM * IFM + DRN + 1) + 1 + 4 * (KK - 1) + 5, t0);
        check_totals(base);

        // Reset at the 10th stream cycle of the second pass, then a clean complete run.
        run(1'b0, -1, 1, 9, 0, t0);
        @(posedge clk); #1;
        check("idle_after_midrun_rst", outs(), 64'd0);
        base = cnt;
        run(1'b0, -1, -1, -1, 4 * (KK + IFM * IFM + DRN + 1) + 1, t0);
        check_totals(base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
